// File: rtl/conv_result_writer_pkg.sv
// Shared frame constants and FSM encodings for the conv result writer.
package conv_result_writer_pkg;

  localparam int CONV_DATA_W     = 24;
  localparam int CONV_ADDR_W     = 17;
  localparam int CONV_WIDTH      = 480;
  localparam int CONV_HEIGHT     = 272;
  localparam int CONV_DEPTH      = CONV_WIDTH * CONV_HEIGHT;
  localparam int CONV_BASE_ADDR  = 0;
  localparam int CONV_FIFO_DEPTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Upstream result handshake plus BRAM write port of the result writer.
interface conv_result_writer_if
  import conv_result_writer_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int ADDR_W = CONV_ADDR_W,
  parameter int ROW_W  = idx_width(CONV_HEIGHT),
  parameter int COL_W  = idx_width(CONV_WIDTH)
);
  logic              start;
  logic              valid;
  logic [DATA_W-1:0] pixel;
  logic              busy;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr_gnt;
  logic              done;
  logic              overflow;
  logic [ROW_W-1:0]  row_cnt;
  logic [COL_W-1:0]  col_cnt;

  modport master (
    output start, valid, pixel, wr_gnt,
    input  busy, cs, we, addr, wdata, done, overflow, row_cnt, col_cnt
  );

  modport slave (
    input  start, valid, pixel, wr_gnt,
    output busy, cs, we, addr, wdata, done, overflow, row_cnt, col_cnt
  );
endinterface

// File: rtl/conv_result_writer_sync_fifo.sv
// Small show-ahead FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [DATA_W-1:0]               din_i,
  output logic [DATA_W-1:0]               dout_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            full_o,
  output logic                            empty_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/conv_result_writer.sv
// Conv pipeline back end: buffers MAC results and writes a frame in raster order.
//
//   state | meaning
//   IDLE  | waiting for start; busy held high, strobes dropped
//   RUN   | accepting results and writing them to BRAM
//   DRAIN | all pixels accepted; flushing the FIFO to BRAM
//   DONE  | single-cycle frame-complete pulse
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int          DATA_W     = CONV_DATA_W,
  parameter int          ADDR_W     = CONV_ADDR_W,
  parameter int          WIDTH      = CONV_WIDTH,
  parameter int          HEIGHT     = CONV_HEIGHT,
  parameter int          DEPTH      = CONV_DEPTH,
  parameter int unsigned BASE_ADDR  = CONV_BASE_ADDR,
  parameter int          FIFO_DEPTH = CONV_FIFO_DEPTH
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  conv_result_writer_if.slave bus
);
  localparam int ROW_W  = idx_width(HEIGHT);
  localparam int COL_W  = idx_width(WIDTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     acc_q, acc_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_last_q, addr_last_d;
  logic [DATA_W-1:0] pix_last_q, pix_last_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              busy_q, busy_d, ovf_q, ovf_d;

  logic              run, writing, push, pop, start_ok;
  logic [DATA_W-1:0] fifo_dout;
  logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
  logic              fifo_full, fifo_empty;

  assign run          = (state_q == S_RUN);
  assign writing      = run || (state_q == S_DRAIN);
  assign pop          = !fifo_empty && bus.wr_gnt && writing;
  assign push         = run && bus.valid && (!fifo_full || pop);
  assign start_ok     = (state_q == S_IDLE) && bus.start;
  assign fifo_cnt_nxt = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.pixel),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, counters, address and sticky overflow.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    addr_last_d = addr_last_q;
    pix_last_d  = pix_last_q;
    row_d       = row_q;
    col_d       = col_q;
    ovf_d       = ovf_q;

    if (start_ok) begin
      acc_d       = '0;
      wr_d        = '0;
      addr_d      = BASE_C;
      addr_last_d = BASE_C;
      row_d       = '0;
      col_d       = '0;
      ovf_d       = 1'b0;
    end

    if (push) acc_d = acc_q + CW'(1);

    if (pop) begin
      wr_d        = wr_q + CW'(1);
      addr_d      = addr_q + ADDR_W'(1);
      addr_last_d = addr_q;
      pix_last_d  = fifo_dout;
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    // Any strobe that does not land in the FIFO is lost.
    if (bus.valid && !push) ovf_d = 1'b1;

    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (acc_d == DEPTH_C) state_d = (wr_d == DEPTH_C) ? S_DONE : S_DRAIN;
      S_DRAIN: if (wr_d == DEPTH_C) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Raised one entry early so a strobe already in flight still fits.
    busy_d = (state_d != S_RUN) ||
             (fifo_cnt_nxt >= FCNT_W'(FIFO_DEPTH - 1)) ||
             (acc_d == DEPTH_C);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      wr_q        <= '0;
      addr_q      <= BASE_C;
      addr_last_q <= BASE_C;
      pix_last_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      addr_last_q <= addr_last_d;
      pix_last_q  <= pix_last_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  // BRAM port shows the live write on a pop, otherwise holds the last write.
  assign bus.cs       = pop;
  assign bus.we       = pop;
  assign bus.addr     = pop ? addr_q : addr_last_q;
  assign bus.wdata    = pop ? fifo_dout : pix_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.overflow = ovf_q;
  assign bus.row_cnt  = row_q;
  assign bus.col_cnt  = col_q;
endmodule
